// File: rtl/ex_pkg.sv
// Shared opcodes, FSM state encoding and forwarding-select constants
// for the execution-stage issue controller.
package ex_pkg;

    localparam logic [4:0] OP_MUL = 5'h0C;
    localparam logic [4:0] OP_DIV = 5'h0D;
    localparam logic [4:0] OP_LD  = 5'h10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        MULTI  = 2'd2,
        BUBBLE = 2'd3
    } ex_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    function automatic logic is_multi(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ex_issue_ctrl_if.sv
// Decode-to-issue handshake: decode is the master, the issue controller the slave.
interface ex_issue_ctrl_if #(
    parameter int OP_W = 5,
    parameter int RA_W = 3
);
    logic            dec_valid;
    logic            dec_ready;
    logic [OP_W-1:0] dec_op;
    logic [RA_W-1:0] dec_rs_a;
    logic [RA_W-1:0] dec_rs_b;
    logic [RA_W-1:0] dec_rd;
    logic            dec_wr;

    modport master (
        output dec_valid, dec_op, dec_rs_a, dec_rs_b, dec_rd, dec_wr,
        input  dec_ready
    );

    modport slave (
        input  dec_valid, dec_op, dec_rs_a, dec_rs_b, dec_rd, dec_wr,
        output dec_ready
    );
endinterface

// File: rtl/ex_issue_ctrl_fwd.sv
// Operand-forwarding comparator: picks register file, EX result or MEM data
// for one source operand.
module fwd_unit
    import ex_pkg::*;
#(
    parameter int RA_W = 3
) (
    input  logic            valid,
    input  logic [RA_W-1:0] rs,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_wr,
    input  logic            ex_ld,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_wr,
    output logic [1:0]      sel
);
    // A load in EX has no result yet, so it never forwards from EX
    always_comb begin
        sel = FWD_RF;
        if (valid && (rs != '0)) begin
            if (ex_wr && !ex_ld && (ex_rd == rs))
                sel = FWD_EX;
            else if (wb_wr && (wb_rd == rs))
                sel = FWD_MEM;
        end
    end
endmodule

// File: rtl/ex_issue_ctrl.sv
// Issue/sequencing controller between decode and the 8-bit execution block:
// multi-cycle hold, load-use bubble and forwarding selects.
module ex_issue_ctrl
    import ex_pkg::*;
#(
    parameter int OP_W      = 5,
    parameter int RA_W      = 3,
    parameter int MULTI_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    ex_issue_ctrl_if.slave  dec,
    output logic [OP_W-1:0] op_ex,
    output logic            ex_en,
    output logic            ex_busy,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [RA_W-1:0] wb_rd,
    output logic            wb_wr
);
    localparam logic [3:0] CNT_INIT = 4'(MULTI_LAT - 1);

    ex_state_t       state;
    logic [3:0]      cnt;
    logic [RA_W-1:0] ex_rd;
    logic            ex_wr;
    logic            ex_ld;
    logic            stall;
    logic            hazard;
    logic            accept;

    // op_ex doubles as the EX-slot opcode; an empty slot reads as NOP
    assign ex_ld  = (op_ex == OP_LD);
    assign stall  = (state == MULTI) && (cnt != '0);
    assign hazard = ex_ld && ex_wr && (ex_rd != '0) && dec.dec_valid &&
                    ((dec.dec_rs_a == ex_rd) || (dec.dec_rs_b == ex_rd));
    assign dec.dec_ready = !reset && !stall && !hazard;
    assign accept = dec.dec_valid && dec.dec_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_ex   <= '0;
            ex_rd   <= '0;
            ex_wr   <= 1'b0;
            ex_en   <= 1'b0;
            ex_busy <= 1'b0;
            wb_rd   <= '0;
            wb_wr   <= 1'b0;
        end else begin
            if (ex_en) begin
                wb_rd <= ex_rd;
                wb_wr <= ex_wr;
            end else begin
                wb_wr <= 1'b0;
            end

            if (stall) begin
                cnt   <= cnt - 4'd1;
                ex_en <= (cnt == 4'd1);
            end else if (accept) begin
                op_ex <= dec.dec_op;
                ex_rd <= dec.dec_rd;
                ex_wr <= dec.dec_wr;
                if (is_multi(dec.dec_op)) begin
                    state   <= MULTI;
                    cnt     <= CNT_INIT;
                    ex_en   <= 1'b0;
                    ex_busy <= 1'b1;
                end else begin
                    state   <= EXEC;
                    cnt     <= '0;
                    ex_en   <= 1'b1;
                    ex_busy <= 1'b0;
                end
            end else begin
                state   <= hazard ? BUBBLE : IDLE;
                cnt     <= '0;
                op_ex   <= '0;
                ex_rd   <= '0;
                ex_wr   <= 1'b0;
                ex_en   <= 1'b0;
                ex_busy <= 1'b0;
            end
        end
    end

    fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .valid (dec.dec_valid),
        .rs    (dec.dec_rs_a),
        .ex_rd (ex_rd),
        .ex_wr (ex_wr),
        .ex_ld (ex_ld),
        .wb_rd (wb_rd),
        .wb_wr (wb_wr),
        .sel   (fwd_a)
    );

    fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .valid (dec.dec_valid),
        .rs    (dec.dec_rs_b),
        .ex_rd (ex_rd),
        .ex_wr (ex_wr),
        .ex_ld (ex_ld),
        .wb_rd (wb_rd),
        .wb_wr (wb_wr),
        .sel   (fwd_b)
    );
endmodule
